// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an async FIFO read port in fixed-length bursts onto a valid/ready stream with m_last, busy and burst_cnt
module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int USEDW_W    = $clog2(FIFO_DEPTH)
) (
  input  logic                  rd_clk,
  input  logic                  rrst_n,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_rd_full,
  input  logic [USEDW_W-1:0]    fifo_rd_usedw,
  input  logic                  cfg_enable,
  input  logic                  cfg_flush,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           burst_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);
  typedef enum logic {IDLE, BURST} state_t;
  state_t                state_q;
  logic [CW-1:0]         remain_q, issued_q, cap_q, usedw, flush_len;
  logic [FIFO_WIDTH-1:0] data_q [2];
  logic [1:0]            last_q, cnt_q;
  logic                  rptr_q, wptr_q, inflight_q, flush_q;
  logic [15:0]           burst_cnt_q;
  logic                  pop, credit_ok, full_start;
  assign m_valid   = cnt_q != 2'd0;
  assign m_data    = data_q[rptr_q];
  assign m_last    = last_q[rptr_q];
  assign busy      = state_q != IDLE;
  assign burst_cnt = burst_cnt_q;
  always_comb begin
    usedw      = CW'(fifo_rd_usedw);
    pop        = m_valid && m_ready;
    credit_ok  = 3'(cnt_q) + 3'(inflight_q) - 3'(pop) < 3'd2;
    full_start = cfg_enable && (fifo_rd_full || usedw >= BL);
    flush_len  = (fifo_rd_full || usedw >= BL) ? BL : (usedw == '0) ? CW'(1) : usedw;
    fifo_rd_en = state_q == BURST && issued_q < remain_q && !fifo_rd_empty && credit_ok;
  end
  always_ff @(posedge rd_clk or negedge rrst_n)
    if (!rrst_n) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      issued_q    <= '0;
      cap_q       <= '0;
      data_q      <= '{default: '0};
      last_q      <= '0;
      cnt_q       <= '0;
      rptr_q      <= 1'b0;
      wptr_q      <= 1'b0;
      inflight_q  <= 1'b0;
      flush_q     <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      flush_q    <= cfg_flush || (flush_q && !(state_q == IDLE && !full_start));
      inflight_q <= fifo_rd_en;
      cnt_q      <= cnt_q + 2'(inflight_q) - 2'(pop);
      if (fifo_rd_en) issued_q <= issued_q + 1'b1;
      if (inflight_q) begin
        data_q[wptr_q] <= fifo_rd_data;
        last_q[wptr_q] <= cap_q == remain_q - 1'b1;
        wptr_q         <= !wptr_q;
        cap_q          <= cap_q + 1'b1;
      end
      if (pop) rptr_q <= !rptr_q;
      if (state_q == IDLE && (full_start || (flush_q && !fifo_rd_empty))) begin
        state_q  <= BURST;
        remain_q <= full_start ? BL : flush_len;
        issued_q <= '0;
        cap_q    <= '0;
      end else if (state_q == BURST && pop && m_last) begin
        state_q     <= IDLE;
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scoreboard bench with a behavioural FIFO model driving fifo_burst_reader
module tb_fifo_burst_reader;
  localparam int W = 16, D = 64, BL = 16, UW = 6;
  logic          rd_clk = 1'b0, rrst_n = 1'b0;
  logic          fifo_rd_en, fifo_rd_empty, fifo_rd_full;
  logic [W-1:0]  fifo_rd_data;
  logic [UW-1:0] fifo_rd_usedw;
  logic          cfg_enable, cfg_flush, m_valid, m_last, m_ready, busy;
  logic [W-1:0]  m_data;
  logic [15:0]   burst_cnt;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  fq [$];
  logic [W:0]    exp_q [$];
  logic [W:0]    e;
  int            fcnt = 0;
  int            n_cmp = 0, n_bad = 0, acc_total = 0, held = 0;
  logic          stall = 1'b0, pl = 1'b0, pop, saw;
  logic [W-1:0]  pd = '0;
  int            first_rd, first_v, base, n;
  always #5 rd_clk = ~rd_clk;
  assign fifo_rd_empty = fcnt == 0;
  assign fifo_rd_full  = fcnt == D;
  assign fifo_rd_usedw = UW'(fcnt);
  fifo_burst_reader #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .BURST_LEN(BL)) dut (
    .rd_clk(rd_clk), .rrst_n(rrst_n), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_full(fifo_rd_full), .fifo_rd_usedw(fifo_rd_usedw),
    .cfg_enable(cfg_enable), .cfg_flush(cfg_flush), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .burst_cnt(burst_cnt));
  always @(posedge rd_clk) begin
    if (!rrst_n) begin
      fq.delete();
      fifo_rd_data <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fcnt <= fq.size();
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask
  task automatic wr_word(input logic [W-1:0] d, input logic last);
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back({last, d});
    step();
    wr_en = 1'b0;
  endtask
  task automatic wr_burst(input int cnt, input int start, input int blen);
    for (int i = 0; i < cnt; i++) wr_word(W'(start + i), ((i + 1) % blen) == 0);
  endtask
  task automatic wait_idle(input string tag, input int budget, input logic bp);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      m_ready = bp ? (k % 3 == 0) : 1'b1;
      step();
      k++;
    end
    m_ready = 1'b1;
    chk(tag, k < budget, 1);
  endtask
  task automatic quiet(input int cycles);
    saw = 1'b0;
    repeat (cycles) begin
      @(negedge rd_clk);
      saw = saw | m_valid | busy | fifo_rd_en;
    end
    step();
  endtask
  initial begin
    cfg_enable = 1'b0; cfg_flush = 1'b0; m_ready = 1'b1; wr_en = 1'b0; wr_data = '0;
    fork
      forever begin
        @(negedge rd_clk);
        if (!rrst_n) begin
          held = 0;
          stall = 1'b0;
        end else begin
          pop = m_valid && m_ready;
          if (fifo_rd_en) begin
            chk("rd_en_while_empty", fifo_rd_empty, 0);
            chk("credit", (held - int'(pop)) < 2, 1);
          end
          if (stall) chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, pl, pd});
          if (pop) begin
            if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
            else begin
              e = exp_q.pop_front();
              chk("data", m_data, e[W-1:0]);
              chk("last", m_last, e[W]);
            end
            acc_total++;
          end
          held = held + int'(fifo_rd_en) - int'(pop);
          stall = m_valid && !m_ready;
          pd = m_data;
          pl = m_last;
        end
      end
    join_none
    repeat (3) step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    rrst_n = 1'b1;
    step();
    wr_burst(16, 1, 16);
    step();
    chk("basic_usedw", fifo_rd_usedw, 16);
    cfg_enable = 1'b1;
    first_rd = 0;
    first_v = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge rd_clk);
      if (fifo_rd_en && first_rd == 0) first_rd = c;
      if (m_valid && first_v == 0) first_v = c;
    end
    chk("lat_rd_en", first_rd, 2);
    chk("lat_m_valid", first_v, 4);
    wait_idle("basic_timeout", 200, 1'b0);
    chk("basic_burst_cnt", burst_cnt, 1);
    chk("basic_empty", fifo_rd_empty, 1);
    cfg_enable = 1'b0;
    wr_burst(64, 'h100, 16);
    step();
    chk("full_flag", fifo_rd_full, 1);
    chk("full_usedw", fifo_rd_usedw, 0);
    cfg_enable = 1'b1;
    wait_idle("full_timeout", 500, 1'b0);
    chk("full_burst_cnt", burst_cnt, 5);
    chk("full_empty", fifo_rd_empty, 1);
    cfg_enable = 1'b0;
    wr_burst(16, 'h200, 16);
    step();
    cfg_enable = 1'b1;
    wait_idle("bp_timeout", 400, 1'b1);
    chk("bp_burst_cnt", burst_cnt, 6);
    cfg_enable = 1'b0;
    wr_burst(5, 'h300, 5);
    step();
    cfg_flush = 1'b1;
    step();
    cfg_flush = 1'b0;
    wait_idle("flush_timeout", 100, 1'b0);
    chk("flush_burst_cnt", burst_cnt, 7);
    chk("flush_empty", fifo_rd_empty, 1);
    cfg_flush = 1'b1;
    step();
    cfg_flush = 1'b0;
    quiet(10);
    chk("flush_on_empty_quiet", saw, 0);
    chk("flush_on_empty_cnt", burst_cnt, 7);
    cfg_enable = 1'b1;
    for (int i = 0; i < 15; i++) wr_word(W'('h400 + i), 1'b0);
    quiet(8);
    chk("threshold_no_read", saw, 0);
    wr_word(W'('h40f), 1'b1);
    wait_idle("threshold_timeout", 100, 1'b0);
    chk("threshold_burst_cnt", burst_cnt, 8);
    cfg_enable = 1'b0;
    wr_burst(16, 'h500, 16);
    step();
    cfg_enable = 1'b1;
    base = acc_total;
    n = 0;
    while (acc_total < base + 7 && n < 100) begin
      @(negedge rd_clk);
      #1;
      n++;
    end
    chk("reset_reach_7", n < 100, 1);
    @(posedge rd_clk);
    #1;
    chk("pre_reset_m_valid", m_valid, 1);
    #1;
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_burst_cnt", burst_cnt, 0);
    exp_q.delete();
    cfg_enable = 1'b0;
    step();
    step();
    rrst_n = 1'b1;
    quiet(10);
    chk("post_rst_quiet", saw, 0);
    chk("post_rst_burst_cnt", burst_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for async_fifo, clocked in the FIFO read domain.
- Drives the FIFO read port: rd_en in, rd_data with 1-cycle latency, rd_empty/rd_full/rd_usedw out.
- Drains data in fixed-length bursts onto a valid/ready stream with an end-of-burst marker.
- Absorbs the RAM read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
- FIFO_WIDTH, 16, data width; must match the FIFO.
- FIFO_DEPTH, 64, FIFO depth; must match the FIFO.
- BURST_LEN, 16, words per burst; legal range 1..FIFO_DEPTH.
- USEDW_W, $clog2(FIFO_DEPTH), derived; not overridden.

Ports:
- rd_clk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- fifo_rd_en  out  1  FIFO read request.
- fifo_rd_data  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_full  in  1  FIFO full.
- fifo_rd_usedw  in  USEDW_W  FIFO fill level; wraps to 0 when full.
- cfg_enable  in  1  level; permits new bursts to start.
- cfg_flush  in  1  single-cycle pulse; requests a short burst of the remaining data.
- m_valid  out  1  stream data valid.
- m_data  out  FIFO_WIDTH  stream data.
- m_last  out  1  final word of the current burst.
- m_ready  in  1  downstream accept.
- busy  out  1  FSM not in IDLE.
- burst_cnt  out  16  completed bursts; wraps at 65535 -> 0.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, buffer empty, in-flight count 0, pending flush cleared. Reset asserted mid-burst discards in-flight and buffered words, and drops m_valid asynchronously.
- Full-burst start condition: cfg_enable && (fifo_rd_full || fifo_rd_usedw >= BURST_LEN). fifo_rd_full is required because usedw reads 0 when the FIFO is full.
- IDLE:
  - Full-burst start true: load remain = BURST_LEN, go to BURST.
  - Else, pending flush && !fifo_rd_empty: load remain = fifo_rd_full ? BURST_LEN : min(fifo_rd_usedw, BURST_LEN), go to BURST.
  - A flush that sees an empty FIFO is cleared with no burst.
- cfg_flush is latched into a pending flag and served at the next IDLE. A full-burst start has priority; the flag stays pending until then.
- BURST:
  - fifo_rd_en = (issued < remain) && !fifo_rd_empty && credit_ok.
  - credit_ok: buffer occupancy + in-flight reads − (m_valid && m_ready) < 2.
  - Each read whose rd_en is high increments issued. Its data is captured into the buffer on the following clock edge.
  - fifo_rd_en is never asserted while fifo_rd_empty = 1.
- Burst end: m_last = 1 on the word whose index equals remain−1. When that word is accepted (m_valid && m_ready && m_last), burst_cnt increments and the FSM returns to IDLE on the next cycle.
- A new burst never overlaps the previous one. IDLE is spent for at least 1 cycle between bursts.
- cfg_enable dropping mid-burst does not abort the burst; the burst completes.
- Stream rules:
  - Once m_valid is asserted, m_data and m_last hold stable until accepted.
  - Words are delivered in FIFO order with no loss or duplication.
- Latency: start condition sampled true in cycle T -> fifo_rd_en high at T+1 -> m_valid high at T+3.
- Throughput: with m_ready held high, one word per cycle once streaming.
- Backpressure: m_ready low stops reads within 1 cycle. At most 2 words are held (buffer + in-flight), and no word is dropped.
- busy = (state != IDLE).

Test Plan:
- Basic burst: preload 16 words 0x0001..0x0010 (usedw = 16), cfg_enable = 1, m_ready = 1 -> 16 consecutive words 0x0001..0x0010; m_valid first high 3 cycles after start; m_last only on 0x0010; burst_cnt = 1; FIFO empty.
- Full FIFO: preload 64 words (usedw reads 0, rd_full = 1), BURST_LEN = 16 -> 4 back-to-back bursts, each with m_last on words 16/32/48/64; burst_cnt = 4.
- Backpressure: 16-word burst with m_ready toggling 1 cycle high / 2 low -> data order intact; m_data stable while m_valid && !m_ready; fifo_rd_en never high with occupancy + in-flight − pop ≥ 2.
- Flush: 5 words in FIFO, cfg_enable = 0, cfg_flush pulse -> 5-word burst, m_last on 5th word; flush pulse with empty FIFO -> no m_valid, busy stays 0.
- Threshold gating: 15 words, cfg_enable = 1 -> no read; 16th word written -> burst starts after the usedw synchroniser delay.
- Reset mid-burst: assert rrst_n = 0 after 7 of 16 words -> m_valid, busy, fifo_rd_en = 0 immediately; burst_cnt = 0; after release no spurious m_valid.
